// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte producers / piso transmitter and uart_tx_arbiter.
// Signals:
//   req, req_data        producer requests and their bytes (byte i at [8*i+7:8*i])
//   ack                  one-cycle done pulse per producer
//   grant_id, busy, err  arbiter status
//   tx_send, tx_data,    drive piso send / data_in / parity_bit
//   tx_parity
//   tx_active, tx_done   piso active_flag / done_flag
// Modports: slave = arbiter side, master = producer/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_parity;
  logic                 tx_active;
  logic                 tx_done;

  modport slave (
    input  req, req_data, tx_active, tx_done,
    output ack, grant_id, busy, err, tx_send, tx_data, tx_parity
  );

  modport master (
    output req, req_data, tx_active, tx_done,
    input  ack, grant_id, busy, err, tx_send, tx_data, tx_parity
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one piso UART transmitter
// between NUM_REQ byte producers. Per granted byte: latch byte (+parity),
// hold it one cycle, pulse tx_send, follow tx_active to frame end, ack.
// Ports:
//   baud_clk  baud-rate clock, all logic on posedge
//   reset     asynchronous active-high reset
//   bus       uart_tx_arbiter_if.slave (requests, acks, status, piso link)
// Parameters: NUM_REQ (2..8), PARITY_ODD, WAIT_LIMIT (1..255).
// Optional feature: define UART_TX_PARITY_EN to compute a real parity bit;
// otherwise tx_parity is a constant mark bit and no XOR tree exists.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic              baud_clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned ID_W   = 3;
  localparam int unsigned SCAN_W = ID_W + 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACT, S_WAIT_DONE, S_ACK
  } state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nx;
  logic [ID_W-1:0]    grant_id, grant_id_nx;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic [NUM_REQ-1:0] ack, ack_nx;
  logic               busy, busy_nx;
  logic               err, err_nx;
  logic               tx_send, tx_send_nx;
  logic [7:0]         tx_data, tx_data_nx;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  logic [7:0]        req_pad_c;
  logic [63:0]       data_pad_c;
  logic [SCAN_W-1:0] scan_c;
  logic              pick_found_c;
  logic [ID_W-1:0]   pick_id_c;
  logic [7:0]        pick_byte_c;

  always_comb begin
    req_pad_c    = 8'(bus.req);
    data_pad_c   = 64'(bus.req_data);
    pick_found_c = 1'b0;
    pick_id_c    = '0;
    scan_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_c = {1'b0, rr_ptr} + SCAN_W'(k);
      if (scan_c >= SCAN_W'(NUM_REQ)) scan_c = scan_c - SCAN_W'(NUM_REQ);
      if (!pick_found_c && req_pad_c[scan_c[ID_W-1:0]]) begin
        pick_found_c = 1'b1;
        pick_id_c    = scan_c[ID_W-1:0];
      end
    end
    pick_byte_c = data_pad_c[{pick_id_c, 3'b000} +: 8];
  end

`ifdef UART_TX_PARITY_EN
  logic tx_parity, tx_parity_nx;
  assign bus.tx_parity = tx_parity;
`else
  // Mark bit in the parity slot; PARITY_ODD has no effect here.
  assign bus.tx_parity = 1'b1 | PARITY_ODD;
`endif

  // State and output registers.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      wait_cnt <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
`ifdef UART_TX_PARITY_EN
      tx_parity <= 1'b1;
`endif
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      grant_id <= grant_id_nx;
      wait_cnt <= wait_cnt_nx;
      ack      <= ack_nx;
      busy     <= busy_nx;
      err      <= err_nx;
      tx_send  <= tx_send_nx;
      tx_data  <= tx_data_nx;
`ifdef UART_TX_PARITY_EN
      tx_parity <= tx_parity_nx;
`endif
    end
  end

  // Next state; registered outputs are computed for the state being entered.
  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    grant_id_nx = grant_id;
    wait_cnt_nx = wait_cnt;
    tx_data_nx  = tx_data;
    ack_nx      = '0;
    err_nx      = 1'b0;
    tx_send_nx  = 1'b0;
`ifdef UART_TX_PARITY_EN
    tx_parity_nx = tx_parity;
`endif
    case (state)
      S_IDLE: begin
        if (pick_found_c) begin
          grant_id_nx = pick_id_c;
          tx_data_nx  = pick_byte_c;
`ifdef UART_TX_PARITY_EN
          tx_parity_nx = (^pick_byte_c) ^ PARITY_ODD;
`endif
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_send_nx = 1'b1;
        state_nx   = S_SEND;
      end
      S_SEND: begin
        wait_cnt_nx = '0;
        state_nx    = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        // err is raised as the count reaches the limit; the ack follows next cycle.
        if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
          ack_nx   = NUM_REQ'(1'b1) << grant_id;
          state_nx = S_ACK;
        end else if (bus.tx_active) begin
          state_nx = S_WAIT_DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
          if (wait_cnt_nx == CNT_W'(WAIT_LIMIT)) err_nx = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_active) begin
          ack_nx   = NUM_REQ'(1'b1) << grant_id;
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        rr_ptr_nx = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  assign bus.ack      = ack;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;
  assign bus.err      = err;
  assign bus.tx_send  = tx_send;
  assign bus.tx_data  = tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned N       = 4;
  localparam bit          PODD    = 1'b1;
  localparam int unsigned WLIM    = 15;
  localparam int unsigned ACT_LEN = 12;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       par;
    bit         err;
  } exp_t;

  logic baud_clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .PARITY_ODD(PODD), .WAIT_LIMIT(WLIM)) dut (
    .baud_clk(baud_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  int   model_rr = 0;
  int   round_id = 0;
  int   round_cyc = 0;
  bit   piso_dead = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_parity(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return (^b) ^ PODD;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: all requests of a round are held until acked, so the grant
  // order is the round-robin walk over the pending set starting at model_rr.
  task automatic predict(input logic [N-1:0] mask, input logic [N*8-1:0] data, input bit dead);
    logic [N-1:0] pend;
    exp_t e;
    pend = mask;
    while (pend != '0) begin
      for (int k = 0; k < int'(N); k++) begin
        int i;
        i = (model_rr + k) % N;
        if (pend[i]) begin
          e.id   = i;
          e.data = data[8*i +: 8];
          e.par  = exp_parity(e.data);
          e.err  = dead;
          exp_q.push_back(e);
          pend[i]  = 1'b0;
          model_rr = (i + 1) % N;
          break;
        end
      end
    end
  endtask

  // Simple piso stand-in: after tx_send, a short random delay, then
  // tx_active for ACT_LEN cycles. When piso_dead it never responds.
  initial begin
    int  delay;
    int  left;
    bit  armed;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    delay = 0; left = 0; armed = 1'b0;
    forever begin
      @(negedge baud_clk);
      bus.tx_done = 1'b0;
      if (reset) begin
        bus.tx_active = 1'b0; armed = 1'b0; left = 0;
      end else if (armed) begin
        if (delay == 0) begin
          armed = 1'b0; bus.tx_active = 1'b1; left = ACT_LEN;
        end else delay--;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          bus.tx_active = 1'b0; bus.tx_done = 1'b1;
        end
      end
      if (!reset && bus.tx_send && !piso_dead) begin
        armed = 1'b1; delay = $urandom_range(0, 2);
      end
    end
  end

  // Monitor: pops the scoreboard on each tx_send, matches the following ack.
  initial begin
    exp_t cur;
    bit   have_cur, prev_send, prev_ack, prev_err;
    int   send_cyc, seen_round;
    have_cur = 0; prev_send = 0; prev_ack = 0; prev_err = 0;
    send_cyc = 0; seen_round = 0;
    forever begin
      @(negedge baud_clk);
      if (reset) begin
        have_cur = 0; prev_send = 0; prev_ack = 0; prev_err = 0;
      end else begin
        if (bus.tx_send) begin
          check("send_no_overlap", prev_send, 0);
          if (exp_q.size() == 0) check("send_unexpected", 1, 0);
          else begin
            cur = exp_q.pop_front();
            have_cur = 1; send_cyc = cyc;
            check("grant_id", bus.grant_id, cur.id);
            check("tx_data", bus.tx_data, cur.data);
            check("tx_parity", bus.tx_parity, cur.par);
            if (round_id != seen_round) begin
              check("req_to_send_latency", cyc - round_cyc, 2);
              seen_round = round_id;
            end
          end
        end
        if (bus.err) begin
          check("err_expected", have_cur && cur.err, 1);
          check("err_timing", cyc - send_cyc, WLIM + 1);
        end
        if (bus.ack != '0) begin
          check("ack_single_pulse", prev_ack, 0);
          if (!have_cur) check("ack_unexpected", bus.ack, 0);
          else begin
            check("ack_onehot", bus.ack, 1 << cur.id);
            check("err_before_ack", prev_err, cur.err);
            check("tx_data_held", bus.tx_data, cur.data);
            check("grant_held", bus.grant_id, cur.id);
            have_cur = 0;
          end
        end
        prev_send = bus.tx_send;
        prev_ack  = |bus.ack;
        prev_err  = bus.err;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_grant"}, bus.grant_id, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_tx_send"}, bus.tx_send, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_parity"}, bus.tx_parity, 1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 60;
    while (bus.busy && budget > 0) begin
      @(negedge baud_clk); budget--;
    end
    if (budget == 0) check("wait_idle_timeout", bus.busy, 0);
  endtask

  // Drives the round until every granted requester is acked; optionally
  // drops a request and changes its byte right after its tx_send.
  task automatic run_round(input int need, input int drop_pct);
    int acks, budget, g;
    acks = 0;
    budget = need * 40 + 20;
    while (acks < need && budget > 0) begin
      @(negedge baud_clk);
      budget--;
      if (bus.tx_send && $urandom_range(0, 99) < drop_pct) begin
        g = int'(bus.grant_id);
        bus.req[g] = 1'b0;
        bus.req_data[8*g +: 8] = ~bus.req_data[8*g +: 8];
      end
      if (bus.ack != '0) begin
        acks++;
        bus.req = bus.req & ~bus.ack;
      end
    end
    check("round_acks", acks, need);
    if (acks < need) exp_q.delete();
    @(negedge baud_clk);
    check("busy_after_round", bus.busy, 0);
  endtask

  task automatic do_round(input logic [N-1:0] mask, input logic [N*8-1:0] data,
                          input bit dead, input int drop_pct);
    wait_idle();
    piso_dead = dead;
    predict(mask, data, dead);
    bus.req_data = data;
    bus.req = mask;
    round_cyc = cyc;
    round_id++;
    run_round($countones(mask), drop_pct);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*8-1:0] d;
    int budget;
    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge baud_clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge baud_clk);

    // Round-robin with all requesting, then requester 0 alone.
    do_round(4'b1111, 32'h44332211, 1'b0, 0);
    do_round(4'b0001, 32'h000000C3, 1'b0, 0);
    // Single request, byte A5 on requester 1.
    do_round(4'b0010, 32'h0000A500, 1'b0, 0);
    // Drop and change after grant.
    do_round(4'b0100, 32'h005A0000, 1'b0, 100);
    // Timeout with a silent transmitter.
    do_round(4'b1000, 32'h7E000000, 1'b1, 0);
    // Parity of a single set bit.
    do_round(4'b0001, 32'h00000001, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(N); i++) d[8*i +: 8] = 8'($urandom);
      do_round(N'($urandom_range(1, (1 << N) - 1)), d,
               ($urandom_range(0, 5) == 0), 30);
    end

    // Reset mid-frame: make rr_ptr non-zero first, then abort a frame.
    do_round(4'b0001, 32'h00000011, 1'b0, 0);
    wait_idle();
    piso_dead = 1'b0;
    predict(4'b0100, 32'h00990000, 1'b0);
    bus.req_data = 32'h00990000;
    bus.req = 4'b0100;
    round_cyc = cyc;
    round_id++;
    budget = 20;
    while (!bus.tx_active && budget > 0) begin
      @(negedge baud_clk); budget--;
    end
    repeat (2) @(negedge baud_clk);
    check("reached_wait_done", bus.tx_active, 1);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    model_rr = 0;
    bus.req_data = 32'h00990066;
    bus.req = 4'b0101;
    predict(4'b0101, 32'h00990066, 1'b0);
    repeat (2) begin
      @(negedge baud_clk);
      check("no_ack_in_reset", bus.ack, 0);
    end
    reset = 1'b0;
    round_cyc = cyc;
    round_id++;
    run_round(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
